// File: rtl/dot_argmax.sv
// dot_argmax: running signed argmax over a frame of NUM_CLASSES neuron
// results, presented on a held valid/ready output with a frame-integrity flag.
module dot_argmax #(
    parameter int unsigned VAL_SIZE    = 26,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VAL_SIZE-1:0] in_value,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_class,
    output logic [VAL_SIZE-1:0] out_value,
    output logic                frame_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [VAL_SIZE-1:0] max_val_q, max_val_d;
    logic [IDX_W-1:0]    max_idx_q, max_idx_d;
    logic [IDX_W-1:0]    out_class_q, out_class_d;
    logic [VAL_SIZE-1:0] out_value_q, out_value_d;
    logic                frame_err_q, frame_err_d;

    logic                accept;
    logic                cnt_full;
    logic                frame_end;
    logic [VAL_SIZE-1:0] cand_val;
    logic [IDX_W-1:0]    cand_idx;

    assign accept    = in_valid & in_ready;
    assign cnt_full  = (cnt_q == LAST_CNT);
    assign frame_end = accept & (in_last | cnt_full);

    // State register
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave COLLECT on frame end, leave HOLD on output transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (frame_end) state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Handshake outputs decoded from the registered state; in_ready is also
    // gated by reset so it reads 0 while reset is held and 1 right after release
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            COLLECT: in_ready  = GlobalReset;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Candidate maximum including the current beat; first beat loads
    // unconditionally, later beats win only on strictly greater (ties keep lower index)
    always_comb begin
        cand_val = max_val_q;
        cand_idx = max_idx_q;
        if (cnt_q == '0) begin
            cand_val = in_value;
            cand_idx = '0;
        end else if ($signed(in_value) > $signed(max_val_q)) begin
            cand_val = in_value;
            cand_idx = cnt_q;
        end
    end

    // Datapath next values: track max per beat, latch result on frame end
    always_comb begin
        cnt_d       = cnt_q;
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        out_class_d = out_class_q;
        out_value_d = out_value_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            max_val_d = cand_val;
            max_idx_d = cand_idx;
            cnt_d     = cnt_q + 1'b1;
            if (frame_end) begin
                cnt_d       = '0;
                out_class_d = cand_idx;
                out_value_d = cand_val;
                frame_err_d = ~(in_last & cnt_full);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            cnt_q       <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            out_class_q <= '0;
            out_value_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            out_class_q <= out_class_d;
            out_value_q <= out_value_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_class = out_class_q;
    assign out_value = out_value_q;
    assign frame_err = frame_err_q;

endmodule
